grant_dispatcher: RTL and testbench



---
 rtl/grant_dispatcher_pkg.sv | 50 +++++
 rtl/grant_event_det.sv | 45 ++++
 rtl/grant_dispatcher.sv | 185 ++++++++++++++++++
 tb/tb_grant_dispatcher.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grant_dispatcher_pkg.sv
// grant_dispatcher_pkg
//   Shared types and helpers for the grant dispatcher:
//   - state_e       : dispatcher FSM state encoding
//   - G_U1..G_U4    : one-hot grant codes (bit3 = U1 ... bit0 = U4)
//   - is_onehot     : true when exactly one grant bit is set
//   - onehot_to_idx : one-hot grant -> requester index (0 = U1 .. 3 = U4)
//   - idx_to_onehot : requester index -> one-hot grant code
package grant_dispatcher_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StSend = 2'd2,
        StDone = 2'd3
    } state_e;

    localparam logic [3:0] G_NONE = 4'b0000;
    localparam logic [3:0] G_U1   = 4'b1000;
    localparam logic [3:0] G_U2   = 4'b0100;
    localparam logic [3:0] G_U3   = 4'b0010;
    localparam logic [3:0] G_U4   = 4'b0001;

    function automatic logic is_onehot(input logic [3:0] g);
        return (g != G_NONE) && ((g & (g - 4'd1)) == G_NONE);
    endfunction

    function automatic logic [1:0] onehot_to_idx(input logic [3:0] g);
        logic [1:0] idx;
        case (g)
            G_U1:    idx = 2'd0;
            G_U2:    idx = 2'd1;
            G_U3:    idx = 2'd2;
            G_U4:    idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
        logic [3:0] g;
        case (idx)
            2'd0:    g = G_U1;
            2'd1:    g = G_U2;
            2'd2:    g = G_U3;
            default: g = G_U4;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/grant_event_det.sv
// grant_event_det
//   Turns the raw arbiter grant into single-cycle grant events.
//   A registered copy of the grant is kept; an event fires only on a cycle
//   where the grant differs from that copy and is one-hot. A changed,
//   nonzero, non-one-hot grant sets a sticky error and produces no event.
// Ports:
//   clk, rst_n : clock, async active-low reset (already release-synchronised)
//   grant      : 4-bit grant from the arbiter
//   ev         : new-grant event this cycle (combinational)
//   ev_idx     : requester index of the event (0 = U1 .. 3 = U4)
//   err        : sticky illegal-grant flag
module grant_event_det
    import grant_dispatcher_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] grant,
    output logic       ev,
    output logic [1:0] ev_idx,
    output logic       err
);

    logic [3:0] grant_q;
    logic       err_q;
    logic       changed;

    assign changed = (grant != grant_q);
    assign ev      = changed && is_onehot(grant);
    assign ev_idx  = onehot_to_idx(grant);
    assign err     = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q <= G_NONE;
            err_q   <= 1'b0;
        end else begin
            grant_q <= grant;
            // Dropping back to zero is a legal change, just not an event.
            if (changed && (grant != G_NONE) && !is_onehot(grant)) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/grant_dispatcher.sv
// grant_dispatcher
//   Serves one-hot arbiter grants as bursts on a shared valid/ready port.
//   Each grant event loads the requester's burst length (0 means 4 beats)
//   and streams that many beats of the requester's live data. One grant
//   arriving while busy is parked in a single pending slot; further ones
//   are dropped and flagged as overflow.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   grant_i             : one-hot grant (bit3 = U1 .. bit0 = U4)
//   data1_i..data4_i    : live beat data per requester
//   len1_i..len4_i      : burst length per requester (0 -> 4 beats)
//   out_valid/out_ready : shared port handshake
//   out_data/out_id     : beat data and requester index (0 = U1 .. 3 = U4)
//   out_last            : final beat of the burst
//   done_o              : one-cycle pulse, one-hot requester, after last beat
//   busy_o              : dispatcher not idle
//   ovf_o, err_o        : sticky pending overflow / illegal grant
module grant_dispatcher
    import grant_dispatcher_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    grant_i,
    input  logic [DW-1:0] data1_i,
    input  logic [DW-1:0] data2_i,
    input  logic [DW-1:0] data3_i,
    input  logic [DW-1:0] data4_i,
    input  logic [1:0]    len1_i,
    input  logic [1:0]    len2_i,
    input  logic [1:0]    len3_i,
    input  logic [1:0]    len4_i,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    out_id,
    output logic          out_last,
    output logic [3:0]    done_o,
    output logic          busy_o,
    output logic          ovf_o,
    output logic          err_o
);

    // Assertion is immediate through the async clear; release is delayed by
    // two clock edges so no flop leaves reset close to an edge.
    logic [1:0] rst_sync_q;
    logic       rst_sync_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_sync_n = rst_sync_q[1];

    logic       ev;
    logic [1:0] ev_idx;
    logic       err;

    grant_event_det u_event_det (
        .clk    (clk),
        .rst_n  (rst_sync_n),
        .grant  (grant_i),
        .ev     (ev),
        .ev_idx (ev_idx),
        .err    (err)
    );

    state_e        state_q;
    logic [1:0]    idx_q;
    logic [2:0]    cnt_q;
    logic          pend_valid_q;
    logic [1:0]    pend_idx_q;
    logic          out_valid_q;
    logic [3:0]    done_q;
    logic          busy_q;
    logic          ovf_q;

    logic [DW-1:0] sel_data;
    logic [1:0]    sel_len;

    always_comb begin
        sel_data = data1_i;
        sel_len  = len1_i;
        case (idx_q)
            2'd0: begin
                sel_data = data1_i;
                sel_len  = len1_i;
            end
            2'd1: begin
                sel_data = data2_i;
                sel_len  = len2_i;
            end
            2'd2: begin
                sel_data = data3_i;
                sel_len  = len3_i;
            end
            default: begin
                sel_data = data4_i;
                sel_len  = len4_i;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q      <= StIdle;
            idx_q        <= 2'd0;
            cnt_q        <= 3'd0;
            pend_valid_q <= 1'b0;
            pend_idx_q   <= 2'd0;
            out_valid_q  <= 1'b0;
            done_q       <= 4'b0000;
            busy_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            // Events seen while busy go to the single pending slot.
            if ((state_q != StIdle) && ev) begin
                if (!pend_valid_q) begin
                    pend_valid_q <= 1'b1;
                    pend_idx_q   <= ev_idx;
                end else begin
                    ovf_q <= 1'b1;
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (pend_valid_q) begin
                        // Older pending request wins; a same-cycle event
                        // takes over the slot being vacated.
                        state_q      <= StLoad;
                        idx_q        <= pend_idx_q;
                        busy_q       <= 1'b1;
                        pend_valid_q <= ev;
                        if (ev) begin
                            pend_idx_q <= ev_idx;
                        end
                    end else if (ev) begin
                        state_q <= StLoad;
                        idx_q   <= ev_idx;
                        busy_q  <= 1'b1;
                    end
                end
                StLoad: begin
                    cnt_q       <= (sel_len == 2'd0) ? 3'd4 : {1'b0, sel_len};
                    state_q     <= StSend;
                    out_valid_q <= 1'b1;
                end
                StSend: begin
                    if (out_ready && (cnt_q != 3'd0)) begin
                        cnt_q <= cnt_q - 3'd1;
                        if (cnt_q == 3'd1) begin
                            state_q     <= StDone;
                            out_valid_q <= 1'b0;
                            done_q      <= idx_to_onehot(idx_q);
                        end
                    end
                end
                StDone: begin
                    done_q  <= 4'b0000;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_valid_q ? sel_data : '0;
    assign out_id    = out_valid_q ? idx_q : 2'd0;
    assign out_last  = out_valid_q && (cnt_q == 3'd1);
    assign done_o    = done_q;
    assign busy_o    = busy_q;
    assign ovf_o     = ovf_q;
    assign err_o     = err;

endmodule

// File: tb/tb_grant_dispatcher.sv
module tb_grant_dispatcher;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [3:0]    grant_i = 4'b0000;
    logic [DW-1:0] dr [4];
    logic [1:0]    ln [4];
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    out_id;
    logic          out_last;
    logic [3:0]    done_o;
    logic          busy_o;
    logic          ovf_o;
    logic          err_o;

    grant_dispatcher #(.DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .grant_i   (grant_i),
        .data1_i   (dr[0]),
        .data2_i   (dr[1]),
        .data3_i   (dr[2]),
        .data4_i   (dr[3]),
        .len1_i    (ln[0]),
        .len2_i    (ln[1]),
        .len3_i    (ln[2]),
        .len4_i    (ln[3]),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_last  (out_last),
        .done_o    (done_o),
        .busy_o    (busy_o),
        .ovf_o     (ovf_o),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: one burst in service at a time, described by how
    // many setup cycles remain, how many beats remain, and whether its
    // completion cycle is due; waiting requests sit in a queue of depth 1.
    bit         m_act;
    int         m_lead;
    int         m_left;
    bit         m_done;
    int         cur_id;
    int         pendq[$];
    bit         m_err;
    bit         m_ovf;
    logic [3:0] m_prev;
    int         m_hold;

    int cyc = 0;
    int beats = 0;
    int dones = 0;
    int fv_cyc = -1;
    int dn_cyc = -1;
    int served[$];

    function automatic int idx_of(input logic [3:0] g);
        for (int i = 0; i < 4; i++) begin
            if (g[3-i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [3:0] oh_of(input int id);
        logic [3:0] g;
        g = 4'b1000;
        return g >> id;
    endfunction

    task automatic model_clear();
        m_act  = 1'b0;
        m_lead = 0;
        m_left = 0;
        m_done = 1'b0;
        cur_id = 0;
        pendq.delete();
        m_err  = 1'b0;
        m_ovf  = 1'b0;
        m_prev = 4'b0000;
    endtask

    function automatic bit in_reset();
        return (!rst_n) || (m_hold > 0);
    endfunction

    task automatic model_check();
        bit            v;
        logic [DW-1:0] d;
        if (in_reset()) begin
            check_eq("rst_out_valid", 32'(out_valid), 32'd0);
            check_eq("rst_out_data", 32'(out_data), 32'd0);
            check_eq("rst_out_id", 32'(out_id), 32'd0);
            check_eq("rst_out_last", 32'(out_last), 32'd0);
            check_eq("rst_done", 32'(done_o), 32'd0);
            check_eq("rst_busy", 32'(busy_o), 32'd0);
            check_eq("rst_ovf", 32'(ovf_o), 32'd0);
            check_eq("rst_err", 32'(err_o), 32'd0);
        end else begin
            v = m_act && (m_lead == 0) && (m_left > 0);
            d = v ? dr[cur_id] : '0;
            check_eq("out_valid", 32'(out_valid), 32'(v));
            check_eq("out_data", 32'(out_data), 32'(d));
            check_eq("out_id", 32'(out_id), v ? 32'(cur_id) : 32'd0);
            check_eq("out_last", 32'(out_last), 32'(v && (m_left == 1)));
            check_eq("done", 32'(done_o), m_done ? 32'(oh_of(cur_id)) : 32'd0);
            check_eq("busy", 32'(busy_o), 32'(m_act));
            check_eq("ovf", 32'(ovf_o), 32'(m_ovf));
            check_eq("err", 32'(err_o), 32'(m_err));
        end
    endtask

    task automatic start_burst(input int id);
        m_act  = 1'b1;
        cur_id = id;
        m_lead = 1;
        m_left = 0;
        m_done = 1'b0;
    endtask

    // Advances the model across the coming rising edge.
    task automatic model_update();
        bit ev;
        bit chg;
        int eid;
        if (!rst_n) begin
            model_clear();
            m_hold = 2;
            return;
        end
        if (m_hold > 0) begin
            model_clear();
            m_hold--;
            return;
        end
        chg = (grant_i != m_prev);
        ev  = chg && ($countones(grant_i) == 1);
        eid = idx_of(grant_i);
        if (chg && (grant_i != 4'b0000) && ($countones(grant_i) != 1)) m_err = 1'b1;
        if (!m_act) begin
            if (pendq.size() > 0) begin
                start_burst(pendq.pop_front());
                if (ev) pendq.push_back(eid);
            end else if (ev) begin
                start_burst(eid);
            end
        end else begin
            if (ev) begin
                if (pendq.size() == 0) pendq.push_back(eid);
                else m_ovf = 1'b1;
            end
            if (m_lead > 0) begin
                m_lead = 0;
                m_left = (ln[cur_id] == 2'd0) ? 4 : int'(ln[cur_id]);
            end else if (m_left > 0) begin
                if (out_ready) begin
                    m_left--;
                    if (m_left == 0) m_done = 1'b1;
                end
            end else if (m_done) begin
                m_done = 1'b0;
                m_act  = 1'b0;
            end
        end
        m_prev = grant_i;
    endtask

    // One clock cycle: fresh data, check at the falling edge, then return
    // just after the next rising edge for the caller to drive inputs.
    task automatic step();
        for (int i = 0; i < 4; i++) dr[i] = DW'($urandom);
        @(negedge clk);
        model_check();
        if (out_valid && out_ready) begin
            beats++;
            if (out_last) served.push_back(int'(out_id));
        end
        if (out_valid && (fv_cyc < 0)) fv_cyc = cyc;
        if (done_o != 4'b0000) begin
            dones++;
            dn_cyc = cyc;
        end
        model_update();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        beats  = 0;
        dones  = 0;
        fv_cyc = -1;
        dn_cyc = -1;
        served.delete();
    endtask

    initial begin
        int n0;
        for (int i = 0; i < 4; i++) begin
            dr[i] = '0;
            ln[i] = 2'd1;
        end
        model_clear();
        m_hold = 2;
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (4) step();

        // Single U2 burst of two beats with ready held high.
        clear_stats();
        out_ready = 1'b1;
        ln[1]     = 2'd2;
        n0        = cyc;
        grant_i   = 4'b0100;
        repeat (7) step();
        check_eq("u2_first_valid_lat", 32'(fv_cyc - n0), 32'd2);
        check_eq("u2_done_lat", 32'(dn_cyc - n0), 32'd4);
        check_eq("u2_beats", 32'(beats), 32'd2);
        grant_i = 4'b0000;
        repeat (2) step();

        // Held grant yields exactly one burst.
        clear_stats();
        ln[0]   = 2'd3;
        grant_i = 4'b1000;
        repeat (10) step();
        grant_i = 4'b0000;
        repeat (4) step();
        check_eq("u1_hold_dones", 32'(dones), 32'd1);
        check_eq("u1_hold_beats", 32'(beats), 32'd3);

        // U3 four-beat burst against a toggling ready.
        clear_stats();
        ln[2]   = 2'd0;
        grant_i = 4'b0010;
        for (int k = 0; k < 14; k++) begin
            out_ready = (k % 2 == 0);
            if (k == 3) ln[2] = 2'd1;
            step();
        end
        out_ready = 1'b1;
        check_eq("u3_toggle_beats", 32'(beats), 32'd4);
        check_eq("u3_toggle_dones", 32'(dones), 32'd1);
        grant_i = 4'b0000;
        repeat (2) step();

        // Three grants during a U1 burst: one parked, two dropped.
        clear_stats();
        ln[0]   = 2'd0;
        ln[1]   = 2'd1;
        grant_i = 4'b1000;
        repeat (2) step();
        grant_i = 4'b0100;
        step();
        grant_i = 4'b0010;
        step();
        grant_i = 4'b0001;
        repeat (14) step();
        check_eq("pend_ovf", 32'(ovf_o), 32'd1);
        check_eq("pend_bursts", 32'(served.size()), 32'd2);
        if (served.size() == 2) begin
            check_eq("pend_first_id", 32'(served[0]), 32'd0);
            check_eq("pend_second_id", 32'(served[1]), 32'd1);
        end
        grant_i = 4'b0000;
        repeat (2) step();

        // Illegal two-hot grant.
        clear_stats();
        grant_i = 4'b0110;
        repeat (4) step();
        check_eq("illegal_err", 32'(err_o), 32'd1);
        check_eq("illegal_beats", 32'(beats), 32'd0);
        grant_i = 4'b0000;
        repeat (2) step();

        // Reset asserted in the middle of a U4 burst.
        clear_stats();
        ln[3]   = 2'd0;
        grant_i = 4'b0001;
        repeat (3) step();
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_out_valid", 32'(out_valid), 32'd0);
        check_eq("async_out_data", 32'(out_data), 32'd0);
        check_eq("async_busy", 32'(busy_o), 32'd0);
        check_eq("async_ovf", 32'(ovf_o), 32'd0);
        check_eq("async_err", 32'(err_o), 32'd0);
        grant_i = 4'b0000;
        repeat (2) step();
        check_eq("async_no_done", 32'(dones), 32'd0);
        rst_n = 1'b1;
        repeat (4) step();
        clear_stats();
        ln[0]   = 2'd2;
        grant_i = 4'b1000;
        repeat (8) step();
        check_eq("post_rst_bursts", 32'(served.size()), 32'd1);
        if (served.size() == 1) check_eq("post_rst_id", 32'(served[0]), 32'd0);
        grant_i = 4'b0000;
        repeat (2) step();

        // Randomised traffic.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(3) == 0) begin
                int r;
                logic [3:0] g;
                r = $urandom_range(19);
                g = 4'b1000;
                if (r == 0) grant_i = 4'b0011;
                else if (r < 6) grant_i = 4'b0000;
                else grant_i = g >> $urandom_range(3);
            end
            for (int i = 0; i < 4; i++) ln[i] = 2'($urandom);
            out_ready = ($urandom_range(3) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
